gpr_write_arbiter: RTL
======================

# gpr_write_arbiter

Shares the single write port of the 32×32 general-purpose register file between two writeback requesters: port 0 for the ALU/immediate path and port 1 for the load/multicycle path. Each requester has a one-entry holding buffer with a valid/ready handshake, and a round-robin arbiter drains the buffers. The winning write drives registered `RegWrite`/`WriteRegisterSelect`/`WriteData` straight into the register file. The block also flags read-after-write hazards for the two register-file read addresses so the pipeline can stall until a buffered write has landed.

## Interface
Parameters:
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register select width (32 registers)

Ports:
- `CLK`  in  1  clock, rising edge
- `RST_N`  in  1  reset, asynchronous, active-low
- `Req0Valid`  in  1  port 0 write request
- `Req0Ready`  out  1  port 0 can accept this cycle
- `Req0Sel`  in  ADDR_W  port 0 destination register
- `Req0Data`  in  DATA_W  port 0 write data
- `Req1Valid`, `Req1Ready`, `Req1Sel`, `Req1Data`  same as port 0, for port 1
- `RegWrite`  out  1  register-file write enable, registered
- `WriteRegisterSelect`  out  ADDR_W  register-file write address, registered
- `WriteData`  out  DATA_W  register-file write data, registered
- `ReadRegister1`, `ReadRegister2`  in  ADDR_W  register-file read addresses to check
- `Hazard1`, `Hazard2`  out  1  pending write targets the corresponding read address

## Operation
- State:
  - per-port buffer: `bufValid`, `bufSel`, `bufData`
  - `rrPtr` (1 bit): the port favoured on a tie
  - output registers
- Grant (combinational, from state only):
  - one buffer valid: grant that port
  - both valid: grant the port `rrPtr` points to
  - neither valid: no grant
- Acceptance: `ReqNReady = !bufValidN || grantN`. Ready never depends on `ReqNValid`, so there is no combinational loop.
- Handshake: a request is accepted at the edge where both `ReqNValid` and `ReqNReady` are high.
  - `ReqNSel != 0`: the buffer loads `Sel`/`Data` and stays valid.
  - `ReqNSel == 0`: the request is consumed and dropped. The buffer stays clear, no write is issued, and `rrPtr` does not change.
- On a grant edge:
  - outputs load the granted buffer's `Sel`/`Data`, and `RegWrite` is set to 1
  - the granted buffer clears unless a new acceptance on the same port reloads it in the same edge (back-to-back)
  - `rrPtr` is set to the non-granted port
- No grant on an edge: `RegWrite` is 0; `WriteRegisterSelect` and `WriteData` hold their previous values.
- Same destination in both buffers: the writes are issued in grant order, and the later grant's data is final in the register file. Ordering between ports is the requesters' responsibility.
- Hazards: `HazardK = (ReadRegisterK != 0)` AND (any valid buffer's `Sel == ReadRegisterK`, OR (`RegWrite` && `WriteRegisterSelect == ReadRegisterK`)). This is purely combinational.

## Timing
- Reset (async assert, sync release):
  - `bufValid0/1 = 0`, `bufSel = 0`, `bufData = 0`, `rrPtr = 0`
  - `RegWrite = 0`, `WriteRegisterSelect = 0`, `WriteData = 0`
  - consequently `Req0Ready = Req1Ready = 1` and `Hazard1 = Hazard2 = 0`
- Reset mid-operation: buffered and in-flight writes are discarded and never reach the register file.
- Latency:
  - request accepted at edge N → buffer valid after N
  - grant at edge N+1 → `RegWrite` high during cycle N+1..N+2
  - register file writes at edge N+2
  - a single active port sustains one write per cycle
- Contention: with both ports streaming, grants alternate every cycle. Aggregate throughput is 1 write/cycle and each port gets 0.5/cycle. The maximum wait for any buffered write is 1 extra cycle.
- A hazard stays asserted from the edge a matching request is accepted until the edge at which the register file has consumed it (`RegWrite` drops or moves to another register).

## Test plan
- Reset, then port 0 sends `Sel = 5`, `Data = 0xDEADBEEF` at edge 1 → `RegWrite = 1`, `WriteRegisterSelect = 5`, `WriteData = 0xDEADBEEF` after edge 2; `Hazard1` high for `ReadRegister1 = 5` from after edge 1 through edge 3.
- Both ports hold valid every cycle (port 0 `Sel = 1`, port 1 `Sel = 2`) for 8 cycles → outputs alternate 1, 2, 1, 2, … starting with port 0; each `ReqNReady` is high every other cycle.
- Port 1 sends `Sel = 0`, `Data = 0x1234` → accepted the same edge, `RegWrite` stays 0, `rrPtr` unchanged, no hazard on `ReadRegister = 0`.
- Port 0 streams `Sel = 3, 4, 5, 6` on consecutive cycles with port 1 idle → 4 consecutive `RegWrite` cycles, `Req0Ready` constantly 1.
- Both buffers hold `Sel = 7` (port 0 data `0xA`, port 1 data `0xB`) with `rrPtr = 1` → writes issue as `0xB` then `0xA`; final R7 = `0xA`.
- Assert `RST_N = 0` mid-cycle while both buffers are valid → `RegWrite`, `Hazard1`, `Hazard2` drop immediately, both ready outputs go to 1, and no write appears after release.

Source files
------------

// File: rtl/gpr_write_arbiter.sv
// Round-robin arbiter sharing the GPR file write port between two buffered writeback requesters,
// with read-after-write hazard flags for the two read addresses.
module gpr_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Req0Valid,
  output logic              Req0Ready,
  input  logic [ADDR_W-1:0] Req0Sel,
  input  logic [DATA_W-1:0] Req0Data,
  input  logic              Req1Valid,
  output logic              Req1Ready,
  input  logic [ADDR_W-1:0] Req1Sel,
  input  logic [DATA_W-1:0] Req1Data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegisterSelect,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic              Hazard1,
  output logic              Hazard2
);

  localparam int unsigned NPORTS = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] sel;
    logic [DATA_W-1:0] data;
  } wrEntry_t;

  wrEntry_t            reqEntry [NPORTS];
  wrEntry_t            bufEntry [NPORTS];
  wrEntry_t            grantEntry;
  logic [NPORTS-1:0]   reqValid;
  logic [NPORTS-1:0]   bufValid;
  logic [NPORTS-1:0]   grant;
  logic [NPORTS-1:0]   ready;
  logic [NPORTS-1:0]   load;
  logic                rrPtr;
  logic [ADDR_W-1:0]   rdAddr [NPORTS];
  logic [NPORTS-1:0]   hazard;

  assign reqEntry[0] = '{sel: Req0Sel, data: Req0Data};
  assign reqEntry[1] = '{sel: Req1Sel, data: Req1Data};
  assign reqValid    = {Req1Valid, Req0Valid};

  // Grant depends on buffer state only; rrPtr breaks ties.
  always_comb begin
    grant = '0;
    case (bufValid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rrPtr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  assign ready      = ~bufValid | grant;
  assign Req0Ready  = ready[0];
  assign Req1Ready  = ready[1];
  assign grantEntry = grant[1] ? bufEntry[1] : bufEntry[0];

  // Writes to r0 are consumed by the handshake but never buffered.
  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      load[i] = reqValid[i] && ready[i] && (reqEntry[i].sel != '0);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bufValid <= '0;
      for (int unsigned i = 0; i < NPORTS; i++) begin
        bufEntry[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if (load[i]) begin
          bufValid[i] <= 1'b1;
          bufEntry[i] <= reqEntry[i];
        end else if (grant[i]) begin
          bufValid[i] <= 1'b0;
        end
      end
    end
  end

  // Register-file write port; select/data hold when idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RegWrite            <= 1'b0;
      WriteRegisterSelect <= '0;
      WriteData           <= '0;
      rrPtr               <= 1'b0;
    end else begin
      RegWrite <= |grant;
      if (|grant) begin
        WriteRegisterSelect <= grantEntry.sel;
        WriteData           <= grantEntry.data;
        rrPtr               <= grant[0];
      end
    end
  end

  assign rdAddr[0] = ReadRegister1;
  assign rdAddr[1] = ReadRegister2;

  // A read address is hazardous while any buffered or in-flight write targets it.
  always_comb begin
    hazard = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      if (rdAddr[k] != '0) begin
        hazard[k] = (bufValid[0] && (bufEntry[0].sel == rdAddr[k])) ||
                    (bufValid[1] && (bufEntry[1].sel == rdAddr[k])) ||
                    (RegWrite && (WriteRegisterSelect == rdAddr[k]));
      end
    end
  end

  assign Hazard1 = hazard[0];
  assign Hazard2 = hazard[1];

endmodule
